// File: rtl/tictactoe_bot_player_if.sv
// Game-core <-> bot-player link: board snapshot, winner, turn and the
// pulse lines the bot uses to steer the game cursor.
//
// Handshake: the game (master) presents a..i, winner and turn as level
// signals that are valid every cycle. The bot (slave) answers with next
// and sel, each a single-cycle pulse, never both in the same cycle.
// There is no ready/ack wire: a sel counts as accepted once the target
// cell becomes non-empty or turn moves away from the bot. ext_next is
// the human's own single-cycle next pulse, mirrored here so the bot can
// keep its shadow of the game cursor aligned.
interface tictactoe_bot_player_if;
  logic [1:0] a, b, c, d, e, f, g, h, i;
  logic [1:0] winner;
  logic       turn;
  logic       ext_next;
  logic       next;
  logic       sel;

  modport master (
    output a, b, c, d, e, f, g, h, i,
    output winner, turn, ext_next,
    input  next, sel
  );

  modport slave (
    input  a, b, c, d, e, f, g, h, i,
    input  winner, turn, ext_next,
    output next, sel
  );
endinterface

// File: rtl/tictactoe_bot_player.sv
// Automated tic-tac-toe opponent. Picks a move (win, block, center,
// corner, first free cell), walks the game cursor there with spaced
// next pulses, places with a sel pulse and waits for the board to
// reflect the move, re-planning if it never does.
module tictactoe_bot_player #(
  parameter int BOT_PLAYER  = 1,
  parameter int PULSE_GAP   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  tictactoe_bot_player_if.slave        game,
  output logic                         busy,
  output logic [3:0]                   target,
  output logic [3:0]                   cursor,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_THINK  = 3'd1,
    S_STEP   = 3'd2,
    S_GAP    = 3'd3,
    S_SELECT = 3'd4,
    S_ACK    = 3'd5
  } state_t;

  localparam logic [1:0] OWN      = (BOT_PLAYER != 0) ? 2'b10 : 2'b01;
  localparam logic [1:0] OPP      = (BOT_PLAYER != 0) ? 2'b01 : 2'b10;
  localparam logic       BOT_TURN = (BOT_PLAYER != 0);

  // One counter serves both the inter-pulse gap and the ack wait.
  localparam int CNT_MAX = (PULSE_GAP > ACK_TIMEOUT) ? PULSE_GAP : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(PULSE_GAP - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  // Corner cells 0, 2, 6, 8.
  localparam logic [8:0] CORNERS = 9'b1_0100_0101;

  // True when both cells hold the given code.
  function automatic logic two_of(input logic [1:0] x, input logic [1:0] y,
                                  input logic [1:0] code);
    return (x == code) && (y == code);
  endfunction

  // Empty cells that would complete a line of 'code'. Each cell lists the
  // partner pairs of every line it belongs to.
  function automatic logic [8:0] line_fill(
    input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
    input logic [1:0] c3, input logic [1:0] c4, input logic [1:0] c5,
    input logic [1:0] c6, input logic [1:0] c7, input logic [1:0] c8,
    input logic [1:0] code);
    logic [8:0] m;
    m[0] = (c0 == 2'b00) & (two_of(c1, c2, code) | two_of(c3, c6, code) |
                            two_of(c4, c8, code));
    m[1] = (c1 == 2'b00) & (two_of(c0, c2, code) | two_of(c4, c7, code));
    m[2] = (c2 == 2'b00) & (two_of(c0, c1, code) | two_of(c5, c8, code) |
                            two_of(c4, c6, code));
    m[3] = (c3 == 2'b00) & (two_of(c4, c5, code) | two_of(c0, c6, code));
    m[4] = (c4 == 2'b00) & (two_of(c3, c5, code) | two_of(c1, c7, code) |
                            two_of(c0, c8, code) | two_of(c2, c6, code));
    m[5] = (c5 == 2'b00) & (two_of(c3, c4, code) | two_of(c2, c8, code));
    m[6] = (c6 == 2'b00) & (two_of(c7, c8, code) | two_of(c0, c3, code) |
                            two_of(c2, c4, code));
    m[7] = (c7 == 2'b00) & (two_of(c6, c8, code) | two_of(c1, c4, code));
    m[8] = (c8 == 2'b00) & (two_of(c6, c7, code) | two_of(c2, c5, code) |
                            two_of(c0, c4, code));
    return m;
  endfunction

  // Lowest set index of a 9-cell mask (0 when empty).
  function automatic logic [3:0] lowest(input logic [8:0] m);
    logic [3:0] r;
    casez (m)
      9'b????????1: r = 4'd0;
      9'b???????10: r = 4'd1;
      9'b??????100: r = 4'd2;
      9'b?????1000: r = 4'd3;
      9'b????10000: r = 4'd4;
      9'b???100000: r = 4'd5;
      9'b??1000000: r = 4'd6;
      9'b?10000000: r = 4'd7;
      9'b100000000: r = 4'd8;
      default:      r = 4'd0;
    endcase
    return r;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_latch;
  logic [3:0]       r_target;
  logic [3:0]       r_cursor;
  logic [3:0]       w_cursor_nxt;
  logic [4:0]       w_sum;
  logic [4:0]       w_sum_wrap;

  logic [8:0]       w_empty;
  logic [8:0]       w_win_mask;
  logic [8:0]       w_blk_mask;
  logic [8:0]       w_corner_mask;
  logic [3:0]       w_choice;
  logic             w_game_over;
  logic             w_my_turn;
  logic             w_abort;
  logic             w_target_filled;
  logic             w_next;
  logic             w_sel;

  assign w_empty = {game.i == 2'b00, game.h == 2'b00, game.g == 2'b00,
                    game.f == 2'b00, game.e == 2'b00, game.d == 2'b00,
                    game.c == 2'b00, game.b == 2'b00, game.a == 2'b00};

  assign w_win_mask = line_fill(game.a, game.b, game.c, game.d, game.e,
                                game.f, game.g, game.h, game.i, OWN);
  assign w_blk_mask = line_fill(game.a, game.b, game.c, game.d, game.e,
                                game.f, game.g, game.h, game.i, OPP);
  assign w_corner_mask = w_empty & CORNERS;

  assign w_game_over     = (game.winner != 2'b00) || (w_empty == 9'd0);
  assign w_my_turn       = (game.turn == BOT_TURN);
  assign w_abort         = !enable || w_game_over || !w_my_turn;
  assign w_target_filled = !w_empty[r_target];

  // Move priority: own win, block, center, first corner, first free cell.
  always_comb begin
    w_choice = 4'd0;
    if (|w_win_mask)         w_choice = lowest(w_win_mask);
    else if (|w_blk_mask)    w_choice = lowest(w_blk_mask);
    else if (w_empty[4])     w_choice = 4'd4;
    else if (|w_corner_mask) w_choice = lowest(w_corner_mask);
    else                     w_choice = lowest(w_empty);
  end

  // Pulses are suppressed in any cycle where the move is being abandoned.
  assign w_next = (r_state == S_STEP)   && !w_abort;
  assign w_sel  = (r_state == S_SELECT) && !w_abort;

  // Shadow cursor: bot and human next pulses both advance it, wrapping at 9.
  assign w_sum        = {1'b0, r_cursor} + {4'd0, w_next} + {4'd0, game.ext_next};
  assign w_sum_wrap   = w_sum - 5'd9;
  assign w_cursor_nxt = (w_sum >= 5'd9) ? w_sum_wrap[3:0] : w_sum[3:0];

  // Next-state and control decode; abort always wins outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_my_turn && !w_game_over) w_state_nxt = S_THINK;
      end
      S_THINK: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_latch     = 1'b1;
          w_state_nxt = (w_choice == w_cursor_nxt) ? S_SELECT : S_STEP;
        end
      end
      S_STEP: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == GAP_LAST) begin
          // Human pulses seen during the gap are already in w_cursor_nxt.
          w_state_nxt = (r_target == w_cursor_nxt) ? S_SELECT : S_STEP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_SELECT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (w_abort || w_target_filled) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == ACK_LAST) begin
          w_state_nxt = S_THINK;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Shared gap / ack-wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Target is captured once per plan, in THINK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_target <= 4'd0;
    else if (w_latch) r_target <= w_choice;
  end

  // Shadow of the game cursor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cursor <= 4'd0;
    else      r_cursor <= w_cursor_nxt;
  end

  assign game.next = w_next;
  assign game.sel  = w_sel;
  assign busy      = (r_state != S_IDLE);
  assign target    = r_target;
  assign cursor    = r_cursor;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tictactoe_bot_player.sv
// Bench for tictactoe_bot_player: directed scenarios plus random boards,
// each move checked against a rule-level model of choice and timing.
module tb_tictactoe_bot_player;
  localparam int GAP    = 4;
  localparam int ACK_TO = 64;
  localparam int STRIDE = 1 + GAP;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       busy;
  logic [3:0] target;
  logic [3:0] cursor;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  tictactoe_bot_player_if gif ();

  tictactoe_bot_player #(
    .BOT_PLAYER (1),
    .PULSE_GAP  (GAP),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .game     (gif),
    .busy     (busy),
    .target   (target),
    .cursor   (cursor),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          m_board[9];
  int          m_cursor;
  int          lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic       s_next, s_sel, s_busy;
  logic [3:0] s_target, s_cursor;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Would placing 'code' on cell j give that code a full line?
  function automatic bit completes(input int j, input int code);
    for (int l = 0; l < 8; l++) begin
      bit on_line = 0;
      int cnt = 0;
      for (int m = 0; m < 3; m++) begin
        if (lines[l][m] == j) on_line = 1;
        else if (m_board[lines[l][m]] == code) cnt++;
      end
      if (on_line && cnt == 2) return 1;
    end
    return 0;
  endfunction

  function automatic int model_choice();
    int corners[4] = '{0, 2, 6, 8};
    for (int j = 0; j < 9; j++) if (m_board[j] == 0 && completes(j, 2)) return j;
    for (int j = 0; j < 9; j++) if (m_board[j] == 0 && completes(j, 1)) return j;
    if (m_board[4] == 0) return 4;
    for (int n = 0; n < 4; n++) if (m_board[corners[n]] == 0) return corners[n];
    for (int j = 0; j < 9; j++) if (m_board[j] == 0) return j;
    return 0;
  endfunction

  function automatic int model_winner();
    for (int l = 0; l < 8; l++) begin
      int v = m_board[lines[l][0]];
      if (v != 0 && m_board[lines[l][1]] == v && m_board[lines[l][2]] == v) return v;
    end
    return 0;
  endfunction

  function automatic bit model_full();
    for (int j = 0; j < 9; j++) if (m_board[j] == 0) return 0;
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_board();
    gif.a = 2'(m_board[0]); gif.b = 2'(m_board[1]); gif.c = 2'(m_board[2]);
    gif.d = 2'(m_board[3]); gif.e = 2'(m_board[4]); gif.f = 2'(m_board[5]);
    gif.g = 2'(m_board[6]); gif.h = 2'(m_board[7]); gif.i = 2'(m_board[8]);
  endtask

  task automatic clear_board();
    for (int j = 0; j < 9; j++) m_board[j] = 0;
    apply_board();
  endtask

  // Inputs are set just after a rising edge; outputs sampled at the falling edge.
  task automatic cycle();
    @(negedge clk);
    s_next = gif.next; s_sel = gif.sel; s_busy = busy;
    s_target = target; s_cursor = cursor;
    @(posedge clk);
    #1;
  endtask

  // Move the shadow cursor with human pulses while the bot is disabled.
  task automatic set_cursor(input int want);
    int n;
    enable = 1'b0;
    n = (want - m_cursor + 9) % 9;
    for (int p = 0; p < n; p++) begin
      gif.ext_next = 1'b1;
      cycle();
      gif.ext_next = 1'b0;
      m_cursor = (m_cursor + 1) % 9;
    end
    cycle();
    check_eq("cursor_pos", s_cursor, m_cursor);
  endtask

  // Let the bot play one move; ext_at >= 0 injects a human next at that
  // offset (must land in the first gap). Offset 0 is the first busy cycle.
  task automatic run_move(input int ext_at, output int sel_t, output int tgt);
    int t, k, kexp, n_over;
    tgt  = model_choice();
    k    = (tgt - m_cursor + 9) % 9;
    kexp = (ext_at >= 0) ? k - 1 : k;
    exp_q.delete();
    for (int j = 0; j < kexp; j++) exp_q.push_back(16'(1 + j * STRIDE));
    gif.winner = 2'b00; gif.turn = 1'b1; gif.ext_next = 1'b0; enable = 1'b1;
    apply_board();
    t = -1; sel_t = -1; n_over = 0;
    for (int c = 0; c < 200 && sel_t < 0; c++) begin
      cycle();
      if (t >= 0) t++;
      else if (s_busy) t = 0;
      if (s_next && s_sel) n_over++;
      if (s_next) begin
        if (exp_q.size() == 0) check_eq("next_extra", t, -1);
        else check_eq("next_time", t, int'(exp_q.pop_front()));
      end
      if (s_sel) begin
        sel_t = t;
        check_eq("target", s_target, tgt);
        check_eq("sel_cursor", s_cursor, tgt);
      end
      gif.ext_next = (ext_at >= 0 && t + 1 == ext_at);
    end
    gif.ext_next = 1'b0;
    check_eq("sel_time", sel_t, 1 + kexp * STRIDE);
    check_eq("next_left", exp_q.size(), 0);
    check_eq("overlap", n_over, 0);
    m_cursor = tgt;
  endtask

  // Game core accepts the move; optionally hands the turn over too.
  task automatic respond(input int tgt, input bit flip);
    m_board[tgt] = 2;
    apply_board();
    if (flip) gif.turn = 1'b0;
    cycle();
    check_eq("ack_busy", s_busy, 1);
    check_eq("ack_pulse", s_next | s_sel, 0);
    cycle();
    check_eq("busy_fall", s_busy, 0);
    enable = 1'b0;
    cycle();
  endtask

  // Drop one abort condition during the first gap of a 4-step move.
  task automatic abort_test(input int kind, input string tag);
    int t, pulses;
    bit reached;
    clear_board();
    set_cursor(0);
    gif.winner = 2'b00; gif.turn = 1'b1; enable = 1'b1;
    t = -1; reached = 0; pulses = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      cycle();
      if (t >= 0) t++;
      else if (s_busy) t = 0;
      if (t >= 3 && (s_next || s_sel)) pulses++;
      if (t == 2) begin
        if (kind == 0) gif.winner = 2'b01;
        else if (kind == 1) gif.turn = 1'b0;
        else enable = 1'b0;
      end
      if (t == 4) begin
        reached = 1;
        check_eq({tag, "_busy"}, s_busy, 0);
        check_eq({tag, "_cursor"}, s_cursor, 1);
      end
    end
    check_eq({tag, "_reached"}, reached, 1);
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (s_next || s_sel || s_busy) pulses++;
    end
    check_eq({tag, "_quiet"}, pulses, 0);
    m_cursor = 1;
    enable = 1'b0; gif.winner = 2'b00; gif.turn = 1'b1;
    cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tgt, st, k, nm, pos, w, t, resel, nn, nb, idle_hits;
    bit reached;

    rst = 1'b0; enable = 1'b0;
    gif.turn = 1'b0; gif.ext_next = 1'b0; gif.winner = 2'b00;
    clear_board();
    m_cursor = 0;
    @(posedge clk); #1;

    // Reset held with random inputs.
    for (int c = 0; c < 6; c++) begin
      enable = 1'($urandom_range(0, 1));
      gif.turn = 1'($urandom_range(0, 1));
      gif.ext_next = 1'($urandom_range(0, 1));
      gif.winner = 2'($urandom_range(0, 2));
      for (int j = 0; j < 9; j++) m_board[j] = $urandom_range(0, 2);
      apply_board();
      cycle();
      check_eq("rst_busy", s_busy, 0);
      check_eq("rst_pulse", s_next | s_sel, 0);
      check_eq("rst_target", s_target, 0);
      check_eq("rst_cursor", s_cursor, 0);
    end
    check_eq("rst_state", dbg_state, 0);

    // Release with the bot disabled.
    enable = 1'b0; gif.ext_next = 1'b0; gif.winner = 2'b00; gif.turn = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check_eq("rel_idle", s_busy | s_next | s_sel, 0);
      check_eq("rel_cursor", s_cursor, 0);
    end

    // Win beats block.
    clear_board();
    m_board[0] = 2; m_board[1] = 2; m_board[3] = 1; m_board[4] = 1;
    run_move(-1, st, tgt);
    check_eq("win_target", tgt, 2);
    respond(tgt, 0);

    // Block that needs the cursor to wrap past 8.
    clear_board();
    m_board[0] = 1; m_board[4] = 1;
    set_cursor(0);
    run_move(-1, st, tgt);
    check_eq("blk_target", tgt, 8);
    respond(tgt, 1);

    // Empty board from cursor 7: center, crossing the wrap.
    clear_board();
    set_cursor(7);
    run_move(-1, st, tgt);
    respond(tgt, 1);

    // Cursor already on the target: sel two cycles in, no next.
    clear_board();
    set_cursor(4);
    run_move(-1, st, tgt);
    check_eq("k0_sel", st, 1);
    respond(tgt, 1);

    // Human next during the first gap shortens the walk.
    clear_board();
    set_cursor(0);
    run_move(2, st, tgt);
    respond(tgt, 1);

    // Aborts during a gap.
    abort_test(0, "abort_win");
    abort_test(1, "abort_turn");
    abort_test(2, "abort_en");

    // Ack timeout: cell never fills, bot re-plans and re-selects in place.
    clear_board();
    set_cursor(0);
    run_move(-1, st, tgt);
    t = st; resel = -1; nn = 0; nb = 0;
    for (int c = 0; c < ACK_TO + 20 && resel < 0; c++) begin
      cycle();
      t++;
      if (s_next) nn++;
      if (!s_busy) nb++;
      if (s_sel) begin
        resel = t;
        check_eq("resel_target", s_target, tgt);
      end
    end
    check_eq("resel_time", resel, st + ACK_TO + 2);
    check_eq("resel_next", nn, 0);
    check_eq("resel_busy", nb, 0);
    respond(tgt, 1);

    // Reset in the middle of a move.
    clear_board();
    set_cursor(0);
    gif.winner = 2'b00; gif.turn = 1'b1; enable = 1'b1;
    t = -1; reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      cycle();
      if (t >= 0) t++;
      else if (s_busy) t = 0;
      if (t == 3) begin
        reached = 1;
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_pulse", gif.next | gif.sel, 0);
        check_eq("mid_rst_cursor", cursor, 0);
        check_eq("mid_rst_target", target, 0);
      end
    end
    check_eq("mid_rst_reached", reached, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_cursor = 0;
    cycle();
    check_eq("post_rst_busy", s_busy, 0);

    // Random boards.
    for (int r = 0; r < 30; r++) begin
      enable = 1'b0; gif.winner = 2'b00; gif.turn = 1'b1;
      clear_board();
      nm = $urandom_range(0, 9);
      for (int m = 0; m < nm; m++) begin
        do pos = $urandom_range(0, 8); while (m_board[pos] != 0);
        m_board[pos] = (m % 2 == 0) ? 1 : 2;
      end
      apply_board();
      w = model_winner();
      if (w != 0 || model_full()) begin
        gif.winner = 2'(w); gif.turn = 1'b1; enable = 1'b1;
        idle_hits = 0;
        for (int c = 0; c < 10; c++) begin
          cycle();
          if (s_busy || s_next || s_sel) idle_hits++;
        end
        check_eq("over_idle", idle_hits, 0);
        enable = 1'b0; gif.winner = 2'b00;
        cycle();
      end else begin
        set_cursor($urandom_range(0, 8));
        k = (model_choice() - m_cursor + 9) % 9;
        run_move((k >= 2 && $urandom_range(0, 3) == 0) ? 2 : -1, st, tgt);
        respond(tgt, 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tictactoe_bot_player.md
Name: tictactoe_bot_player

Overview:
- Automated opponent for the tic-tac-toe game core: the responder on the game's sel/next input interface.
- Reads the 9-cell board, winner and current-turn outputs, chooses a move, and drives single-cycle next pulses until the cursor reaches the chosen cell, then a single-cycle sel pulse.
- Sits beside the game core in the top level. The top level ORs its next/sel with the human's debounced pulses when bot mode is enabled.

Parameters:
- BOT_PLAYER, 1, turn value the bot plays (0 = player 1 code 01, 1 = player 2 code 10).
- PULSE_GAP, 4, idle cycles after each next pulse before the next action (>=1).
- ACK_TIMEOUT, 64, cycles to wait for the selected cell to fill before re-planning.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  bot mode on
- turn  in  1  current player from the game core
- ext_next  in  1  human next pulse, single-cycle; tracked for the shadow cursor
- a,b,c,d,e,f,g,h,i  in  2 each  board cells 0..8, row-major; 00 empty, 01 p1, 10 p2
- winner  in  2  00 none, 01 p1, 10 p2
- next  out  1  single-cycle cursor-advance pulse
- sel  out  1  single-cycle place pulse
- busy  out  1  high in any state other than IDLE
- target  out  4  latched chosen cell 0..8
- cursor  out  4  shadow of the game cursor 0..8

Behaviour:
- Reset (rst=0, async): state IDLE; next=0, sel=0, busy=0, target=0, cursor=0.
- Cursor model: the game cursor starts at 0 after reset. It advances by 1 on each next pulse and wraps from 8 to 0.
- Shadow cursor update: cursor increments mod 9 on each bot next pulse or ext_next. If both occur in the same cycle, it increments by 2 mod 9.
- Game over: winner!=00 or no empty cell.
- Move choice, evaluated combinationally in THINK:
  1. Cell completing a bot line (own-own-empty), out of 8 lines.
  2. Else cell blocking an opponent line.
  3. Else center 4 if empty.
  4. Else first empty corner in order 0,2,6,8.
  5. Else lowest empty index.
  - Ties within a rule are broken by lowest cell index.
- FSM states and transitions:
  - IDLE: go to THINK when enable & turn==BOT_PLAYER & !game over.
  - THINK (1 cycle): latch target. Go to SELECT if cursor==target, else STEP.
  - STEP (1 cycle): next=1, cursor advances; go to GAP.
  - GAP: hold PULSE_GAP cycles. Then SELECT if cursor==target, else STEP.
  - SELECT (1 cycle): sel=1; go to ACK.
  - ACK: go to IDLE when the target cell !=00 or turn!=BOT_PLAYER. After ACK_TIMEOUT cycles with neither, go to THINK and re-plan.
- Abort: in THINK/STEP/GAP/SELECT/ACK, !enable, game over, or turn!=BOT_PLAYER forces IDLE on the next edge. This takes priority over any pending pulse; no next or sel is issued in that cycle.
- next and sel are never high in the same cycle, and each is high for exactly one cycle.
- Move latency with k next pulses: 1 (THINK) + k*(1+PULSE_GAP) + 1 (SELECT) cycles from leaving IDLE to sel.
- k = (target - cursor) mod 9, range 0..8.
- ext_next during STEP/GAP updates the shadow cursor; the GAP-end comparison uses the updated value.
- Reset mid-move: outputs clear immediately; no further pulses are issued.

Test Plan:
1. Hold rst=0 with random inputs -> next=sel=busy=0, target=cursor=0; release reset with enable=0 -> outputs stay 0.
2. Win beats block: BOT_PLAYER=1, turn=1, a=b=10, d=e=01, cursor 0 -> target=2.
   - Expect next pulses at cycle offsets 1 and 1+(1+PULSE_GAP), cursor 0->1->2, then sel once.
   - Drive c=10 -> busy falls the following cycle.
3. Block with wrap: a=e=01, opponent p1, no bot line, cursor 0 -> target=8, 8 next pulses, then sel.
   - Separately: 7 ext_next pulses (cursor=7), empty board -> target=4, next pulses take cursor 7->8->0->1->2->3->4, then sel.
4. Empty board, cursor=4 -> target=4; sel 2 cycles after leaving IDLE, no next pulse.
5. Abort: during GAP, set winner=01 -> no further next/sel, busy=0 next cycle.
   - Repeat with turn toggled and with enable dropped -> same result.
6. ACK timeout: board cell never fills after sel, turn stays at bot -> after ACK_TIMEOUT cycles re-enter THINK.
   - Same target, cursor==target -> sel reissued with no next pulse.
